hazard_scoreboard: RTL and testbench

Parametrised next-generation pipeline hazard controller for the 5-stage MIPS core. It adds a multi-cycle execute unit (MDU) scoreboard to the existing forwarding, load-use and branch-in-decode hazard logic. It also keeps a saturating stall-cycle counter for performance analysis. It sits beside the pipeline registers and drives their stall, flush and forward-select controls.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/mdu_tracker.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select codes
// and the MDU tracker state encoding.
package cpu_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_tracker.sv
// Tracks one in-flight multi-cycle MDU operation: its destination register,
// the remaining latency and the single-cycle write-back slot.
module mdu_tracker
    import cpu_pkg::*;
#(
    parameter int AW      = 5,
    parameter int MDU_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue,
    input  logic [AW-1:0] issue_reg,
    output logic          busy,
    output logic          wb_valid,
    output logic [AW-1:0] pend_reg
);

    mdu_state_t state;
    logic [3:0] cnt;

    // An issue seen while BUSY is ignored; the structural stall keeps it from happening.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            pend_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        cnt      <= 4'(MDU_LAT - 1);
                        pend_reg <= issue_reg;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == BUSY);
    assign wb_valid = (state == BUSY) && (cnt == 4'd1);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/MDU stalls,
// flush control and a saturating stall-cycle counter.
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int AW      = 5,
    parameter int MDU_LAT = 4,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   RsD,
    input  logic [AW-1:0]   RtD,
    input  logic            UsesRsD,
    input  logic            UsesRtD,
    input  logic            BranchD,
    input  logic            MultiD,
    input  logic            RegWriteD,
    input  logic [AW-1:0]   WriteRegD,
    input  logic            PCSrcD,
    input  logic [AW-1:0]   RsE,
    input  logic [AW-1:0]   RtE,
    input  logic [AW-1:0]   WriteRegE,
    input  logic            RegWriteE,
    input  logic            MemtoRegE,
    input  logic            MduIssueE,
    input  logic [AW-1:0]   WriteRegM,
    input  logic            RegWriteM,
    input  logic            MemtoRegM,
    input  logic [AW-1:0]   WriteRegW,
    input  logic            RegWriteW,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic            ForwardAD,
    output logic            ForwardBD,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            MduBusy,
    output logic            MduWbValid,
    output logic [AW-1:0]   MduWbReg,
    output logic [CNTW-1:0] StallCount
);

    logic [AW-1:0] pend_reg;
    logic          load_use;
    logic          branch_haz;
    logic          mdu_raw;
    logic          mdu_waw;
    logic          mdu_struct;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a == b) && (a != '0);
    endfunction

    function automatic logic used_hit(input logic [AW-1:0] dst);
        return (UsesRsD && hit(dst, RsD)) || (UsesRtD && hit(dst, RtD));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        if (RegWriteM && hit(WriteRegM, src)) return FWD_MEM;
        else if (RegWriteW && hit(WriteRegW, src)) return FWD_WB;
        else return FWD_RF;
    endfunction

    mdu_tracker #(
        .AW      (AW),
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .issue     (MduIssueE),
        .issue_reg (WriteRegE),
        .busy      (MduBusy),
        .wb_valid  (MduWbValid),
        .pend_reg  (pend_reg)
    );

    assign ForwardAE = fwd_sel(RsE);
    assign ForwardBE = fwd_sel(RtE);
    assign ForwardAD = RegWriteM && !MemtoRegM && hit(WriteRegM, RsD);
    assign ForwardBD = RegWriteM && !MemtoRegM && hit(WriteRegM, RtD);

    // The RAW waiter is released in the write-back cycle: the register file
    // writes in the first half-cycle, so decode reads the fresh value.
    assign load_use   = MemtoRegE && RegWriteE && used_hit(WriteRegE);
    assign branch_haz = BranchD && ((RegWriteE && used_hit(WriteRegE)) ||
                                    (MemtoRegM && used_hit(WriteRegM)));
    assign mdu_raw    = MduBusy && !MduWbValid && used_hit(pend_reg);
    assign mdu_waw    = MduBusy && RegWriteD && (WriteRegD == pend_reg);
    assign mdu_struct = MduBusy && MultiD;

    assign StallD = load_use || branch_haz || mdu_raw || mdu_waw || mdu_struct;
    assign StallF = StallD;
    assign FlushE = StallD;
    assign FlushD = PCSrcD && !StallD;

    assign MduWbReg = MduWbValid ? pend_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
        end else if (StallD && (StallCount != {CNTW{1'b1}})) begin
            StallCount <= StallCount + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed table, hand-written
// MDU/reset/saturation sequences and randomized traffic against a cycle-age model.
module tb_hazard_scoreboard;

    localparam int AW      = 5;
    localparam int MDU_LAT = 4;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    typedef struct packed {
        logic [4:0] rsD;
        logic [4:0] rtD;
        logic       usesRsD;
        logic       usesRtD;
        logic       branchD;
        logic       multiD;
        logic       regWriteD;
        logic [4:0] writeRegD;
        logic       pcSrcD;
        logic [4:0] rsE;
        logic [4:0] rtE;
        logic [4:0] writeRegE;
        logic       regWriteE;
        logic       memtoRegE;
        logic       mduIssueE;
        logic [4:0] writeRegM;
        logic       regWriteM;
        logic       memtoRegM;
        logic [4:0] writeRegW;
        logic       regWriteW;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic       stallD;
        logic       flushD;
        logic [1:0] fwdAE;
        logic [1:0] fwdBE;
        logic       fwdAD;
        logic       fwdBD;
    } vec_t;

    logic            clk, rst;
    logic [AW-1:0]   RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic            UsesRsD, UsesRtD, BranchD, MultiD, RegWriteD, PCSrcD;
    logic            RegWriteE, MemtoRegE, MduIssueE, RegWriteM, MemtoRegM, RegWriteW;
    logic            StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
    logic [1:0]      ForwardAE, ForwardBE;
    logic            MduBusy, MduWbValid;
    logic [AW-1:0]   MduWbReg;
    logic [CNTW-1:0] StallCount;

    int    testsRun   = 0;
    int    testsFail  = 0;
    int    modelCycle = 0;
    int    issueCycle = 0;
    bit    issueValid = 0;
    int    pendM      = 0;
    int    stallCntM  = 0;
    bit    expStall, expBusy, expWb;
    stim_t curStim;
    logic  curRst;

    hazard_scoreboard #(
        .AW      (AW),
        .MDU_LAT (MDU_LAT),
        .CNTW    (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RsD        (RsD),
        .RtD        (RtD),
        .UsesRsD    (UsesRsD),
        .UsesRtD    (UsesRtD),
        .BranchD    (BranchD),
        .MultiD     (MultiD),
        .RegWriteD  (RegWriteD),
        .WriteRegD  (WriteRegD),
        .PCSrcD     (PCSrcD),
        .RsE        (RsE),
        .RtE        (RtE),
        .WriteRegE  (WriteRegE),
        .RegWriteE  (RegWriteE),
        .MemtoRegE  (MemtoRegE),
        .MduIssueE  (MduIssueE),
        .WriteRegM  (WriteRegM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .WriteRegW  (WriteRegW),
        .RegWriteW  (RegWriteW),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAD  (ForwardAD),
        .ForwardBD  (ForwardBD),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .MduBusy    (MduBusy),
        .MduWbValid (MduWbValid),
        .MduWbReg   (MduWbReg),
        .StallCount (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit hit(input int a, input int b);
        return (a == b) && (a != 0);
    endfunction

    function automatic bit usedHit(input int dst, input stim_t s);
        return (s.usesRsD && hit(dst, int'(s.rsD))) || (s.usesRtD && hit(dst, int'(s.rtD)));
    endfunction

    function automatic int fwdE(input int src, input stim_t s);
        if (s.regWriteM && hit(int'(s.writeRegM), src)) return 2;
        if (s.regWriteW && hit(int'(s.writeRegW), src)) return 1;
        return 0;
    endfunction

    task automatic checkValue(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFail++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, modelCycle);
        end
    endtask

    // Compares every output against the model for the inputs currently driven.
    task automatic checkOutput();
        int age;
        stim_t s;
        s       = curStim;
        age     = modelCycle - issueCycle;
        expBusy = issueValid && (age >= 1) && (age <= MDU_LAT - 1);
        expWb   = issueValid && (age == MDU_LAT - 1);
        expStall = (s.memtoRegE && s.regWriteE && usedHit(int'(s.writeRegE), s))
                || (s.branchD && ((s.regWriteE && usedHit(int'(s.writeRegE), s))
                                  || (s.memtoRegM && usedHit(int'(s.writeRegM), s))))
                || (expBusy && !expWb && usedHit(pendM, s))
                || (expBusy && s.regWriteD && (int'(s.writeRegD) == pendM))
                || (expBusy && s.multiD);
        checkValue("StallD", int'(StallD), int'(expStall));
        checkValue("StallF", int'(StallF), int'(expStall));
        checkValue("FlushE", int'(FlushE), int'(expStall));
        checkValue("FlushD", int'(FlushD), int'(s.pcSrcD && !expStall));
        checkValue("ForwardAE", int'(ForwardAE), fwdE(int'(s.rsE), s));
        checkValue("ForwardBE", int'(ForwardBE), fwdE(int'(s.rtE), s));
        checkValue("ForwardAD", int'(ForwardAD),
                   int'(s.regWriteM && !s.memtoRegM && hit(int'(s.writeRegM), int'(s.rsD))));
        checkValue("ForwardBD", int'(ForwardBD),
                   int'(s.regWriteM && !s.memtoRegM && hit(int'(s.writeRegM), int'(s.rtD))));
        checkValue("MduBusy", int'(MduBusy), int'(expBusy));
        checkValue("MduWbValid", int'(MduWbValid), int'(expWb));
        checkValue("MduWbReg", int'(MduWbReg), expWb ? pendM : 0);
        checkValue("StallCount", int'(StallCount), stallCntM);
    endtask

    task automatic applyStimulus(input stim_t s, input logic r);
        curStim   = s;
        curRst    = r;
        rst       = r;
        RsD       = s.rsD;       RtD       = s.rtD;
        UsesRsD   = s.usesRsD;   UsesRtD   = s.usesRtD;
        BranchD   = s.branchD;   MultiD    = s.multiD;
        RegWriteD = s.regWriteD; WriteRegD = s.writeRegD;
        PCSrcD    = s.pcSrcD;
        RsE       = s.rsE;       RtE       = s.rtE;
        WriteRegE = s.writeRegE; RegWriteE = s.regWriteE;
        MemtoRegE = s.memtoRegE; MduIssueE = s.mduIssueE;
        WriteRegM = s.writeRegM; RegWriteM = s.regWriteM;
        MemtoRegM = s.memtoRegM;
        WriteRegW = s.writeRegW; RegWriteW = s.regWriteW;
        #1;
        checkOutput();
    endtask

    // Clock edge: advance the model by one cycle using the inputs just applied.
    task automatic advance();
        @(posedge clk);
        if (curRst) begin
            issueValid = 0;
            pendM      = 0;
            stallCntM  = 0;
        end else begin
            if (expStall && stallCntM < CMAX) stallCntM++;
            if (expBusy) begin
                if (expWb) issueValid = 0;
            end else if (curStim.mduIssueE) begin
                issueValid = 1;
                issueCycle = modelCycle;
                pendM      = int'(curStim.writeRegE);
            end
        end
        modelCycle++;
        @(negedge clk);
    endtask

    task automatic step(input stim_t s, input logic r);
        applyStimulus(s, r);
        advance();
    endtask

    vec_t  vecs[$];
    vec_t  v;
    stim_t z, d, s;
    logic [63:0] rnd;

    initial begin
        z = '0;
        rst = 1'b1;
        curStim = z;
        curRst  = 1'b1;
        {RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {UsesRsD, UsesRtD, BranchD, MultiD, RegWriteD, PCSrcD} = '0;
        {RegWriteE, MemtoRegE, MduIssueE, RegWriteM, MemtoRegM, RegWriteW} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state with all inputs low: every output zero.
        applyStimulus(z, 1'b0);
        checkValue("reset_StallCount", int'(StallCount), 0);
        checkValue("reset_MduBusy", int'(MduBusy), 0);
        advance();

        v = '0; v.s.regWriteM = 1; v.s.writeRegM = 8; v.s.regWriteW = 1; v.s.writeRegW = 8;
        v.s.rsE = 8; v.fwdAE = 2'b10; vecs.push_back(v);
        v.s.rsE = 0; v.fwdAE = 2'b00; vecs.push_back(v);
        v = '0; v.s.regWriteW = 1; v.s.writeRegW = 3; v.s.rtE = 3; v.fwdBE = 2'b01; vecs.push_back(v);
        v = '0; v.s.regWriteM = 1; v.s.writeRegM = 6; v.s.rsD = 6; v.s.rtD = 6;
        v.fwdAD = 1; v.fwdBD = 1; vecs.push_back(v);
        v.s.memtoRegM = 1; v.fwdAD = 0; v.fwdBD = 0; vecs.push_back(v);
        v = '0; v.s.branchD = 1; v.s.regWriteE = 1; v.s.writeRegE = 4; v.s.rsD = 4;
        v.s.usesRsD = 1; v.s.pcSrcD = 1; v.stallD = 1; vecs.push_back(v);
        v = '0; v.s.branchD = 1; v.s.rsD = 4; v.s.usesRsD = 1; v.s.pcSrcD = 1;
        v.flushD = 1; vecs.push_back(v);
        v = '0; v.s.memtoRegE = 1; v.s.regWriteE = 1; v.s.writeRegE = 9; v.s.rtD = 9; vecs.push_back(v);
        v = '0; v.s.branchD = 1; v.s.memtoRegM = 1; v.s.writeRegM = 2; v.s.rtD = 2;
        v.s.usesRtD = 1; v.stallD = 1; vecs.push_back(v);
        v = '0; vecs.push_back(v);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].s, 1'b0);
            checkValue("tbl_StallD", int'(StallD), int'(vecs[i].stallD));
            checkValue("tbl_FlushD", int'(FlushD), int'(vecs[i].flushD));
            checkValue("tbl_ForwardAE", int'(ForwardAE), int'(vecs[i].fwdAE));
            checkValue("tbl_ForwardBE", int'(ForwardBE), int'(vecs[i].fwdBE));
            checkValue("tbl_ForwardAD", int'(ForwardAD), int'(vecs[i].fwdAD));
            checkValue("tbl_ForwardBD", int'(ForwardBD), int'(vecs[i].fwdBD));
            advance();
        end

        // Load-use stalls one cycle and bumps the counter by one.
        step(z, 1'b1);
        d = '0; d.memtoRegE = 1; d.regWriteE = 1; d.writeRegE = 9; d.rtD = 9; d.usesRtD = 1;
        applyStimulus(d, 1'b0);
        checkValue("lu_StallD", int'(StallD), 1);
        checkValue("lu_StallF", int'(StallF), 1);
        checkValue("lu_FlushE", int'(FlushE), 1);
        advance();
        applyStimulus(z, 1'b0);
        checkValue("lu_StallCount", int'(StallCount), 1);
        advance();

        // MDU issue to r12, dependent D instruction waits two cycles.
        s = '0; s.mduIssueE = 1; s.writeRegE = 12;
        applyStimulus(s, 1'b0);
        checkValue("mdu_busy_before", int'(MduBusy), 0);
        advance();
        d = '0; d.rsD = 12; d.usesRsD = 1;
        applyStimulus(d, 1'b0);
        checkValue("mdu_raw1_StallD", int'(StallD), 1);
        checkValue("mdu_raw1_Busy", int'(MduBusy), 1);
        advance();
        applyStimulus(d, 1'b0);
        checkValue("mdu_raw2_StallD", int'(StallD), 1);
        checkValue("mdu_raw2_Wb", int'(MduWbValid), 0);
        advance();
        applyStimulus(d, 1'b0);
        checkValue("mdu_release_StallD", int'(StallD), 0);
        checkValue("mdu_release_Wb", int'(MduWbValid), 1);
        checkValue("mdu_release_WbReg", int'(MduWbReg), 12);
        advance();
        applyStimulus(z, 1'b0);
        checkValue("mdu_idle_Busy", int'(MduBusy), 0);
        advance();

        // Second MDU op in D while busy stalls structurally.
        s = '0; s.mduIssueE = 1; s.writeRegE = 5;
        step(s, 1'b0);
        d = '0; d.multiD = 1;
        applyStimulus(d, 1'b0);
        checkValue("mdu_struct_StallD", int'(StallD), 1);
        advance();
        repeat (3) step(z, 1'b0);

        // Reset one cycle after issue abandons the op with no write-back.
        s = '0; s.mduIssueE = 1; s.writeRegE = 7;
        step(s, 1'b0);
        applyStimulus(z, 1'b1);
        checkValue("rstmid_Busy_before", int'(MduBusy), 1);
        advance();
        applyStimulus(z, 1'b0);
        checkValue("rstmid_Busy", int'(MduBusy), 0);
        checkValue("rstmid_StallCount", int'(StallCount), 0);
        advance();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(z, 1'b0);
            checkValue("rstmid_noWb", int'(MduWbValid), 0);
            advance();
        end

        // Counter saturates at 15 with a 4-bit width.
        d = '0; d.memtoRegE = 1; d.regWriteE = 1; d.writeRegE = 9; d.rtD = 9; d.usesRtD = 1;
        repeat (20) step(d, 1'b0);
        applyStimulus(z, 1'b0);
        checkValue("sat_StallCount", int'(StallCount), 15);
        advance();

        // Randomized traffic on a small register set to provoke collisions.
        step(z, 1'b1);
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom, $urandom};
            s = rnd[$bits(stim_t)-1:0];
            s.rsD       = 5'($urandom_range(0, 3));
            s.rtD       = 5'($urandom_range(0, 3));
            s.writeRegD = 5'($urandom_range(0, 3));
            s.rsE       = 5'($urandom_range(0, 3));
            s.rtE       = 5'($urandom_range(0, 3));
            s.writeRegE = 5'($urandom_range(0, 3));
            s.writeRegM = 5'($urandom_range(0, 3));
            s.writeRegW = 5'($urandom_range(0, 3));
            s.mduIssueE = ($urandom_range(0, 4) == 0);
            s.multiD    = ($urandom_range(0, 3) == 0);
            step(s, ($urandom_range(0, 59) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
